ma_task_packetizer: RTL
=======================

// Module: ma_task_packetizer
// PURPOSE
//  Consumes the flit stream of task images produced by the MA parser and wraps each task image in a NoC packet for the target PE.
//  - Input per task: text_size, data_size, bss_size, entry_point, then (text_size+data_size)/4 binary words.
//  - Output packet: header, size, service, task_id, 4 descriptor words, binary words.
//  - Sits between the parser and the injector's NoC local port.
// PARAMETERS
//  FLIT_SIZE   32           flit width in bits (>= 32)
//  SVC_ALLOC   32'h0000_0040 service code placed in the service flit
// PORTS
//  clk_i            in   1          clock, rising edge
//  rst_ni           in   1          asynchronous, active-high reset
//  src_tx_i         in   1          input flit valid
//  src_credit_o     out  1          input ready; flit accepted when src_tx_i & src_credit_o at posedge
//  src_data_i       in   FLIT_SIZE  input flit
//  target_addr_i    in   16         destination PE (XY); sampled when text_size is accepted
//  noc_tx_o         out  1          output flit valid
//  noc_credit_i     in   1          NoC ready; flit sent when noc_tx_o & noc_credit_i at posedge
//  noc_data_o       out  FLIT_SIZE  output flit
//  pkt_done_o       out  1          1-cycle pulse after the last flit of a packet is sent
//  task_cnt_o       out  16         packets completed since reset
// BEHAVIOUR
//  Reset: state=CAP_TEXT, src_credit_o=0, noc_tx_o=0, noc_data_o=0, pkt_done_o=0, task_cnt_o=0, task_id=0.
//    src_credit_o goes to 1 in the first cycle after reset deasserts.
//  Assertion of rst_ni at any time aborts the packet in flight; nothing is resent.
//  FSM states:
//   CAP_TEXT  src_credit_o=1. On accept: text<=data, dest<=target_addr_i. Go to CAP_DATA.
//   CAP_DATA  src_credit_o=1. On accept: dsz<=data; words<=(text+data)>>2.
//             Low 2 bits are truncated; sum is FLIT_SIZE wide, wrap ignored. Go to HDR.
//   HDR       noc_data_o={zero-ext,dest}, noc_tx_o=1.
//   SIZE      noc_data_o=words+6.
//   SVC       noc_data_o=SVC_ALLOC.
//   ID        noc_data_o=task_id.
//   TXT       noc_data_o=text.
//   DAT       noc_data_o=dsz.
//    HDR through DAT: src_credit_o=0; each state advances on noc_credit_i.
//   PASS      Forwards bss, entry, then `words` binary words.
//             noc_tx_o=src_tx_i, noc_data_o=src_data_i, src_credit_o=noc_credit_i (combinational, zero latency).
//             remaining=words+2 on entry; decrement on each transfer.
//             Transfer with remaining==1: pkt_done_o=1 next cycle, task_cnt_o++, task_id++, go to CAP_TEXT.
//  words==0: the packet ends after the entry_point flit (size flit=6).
//  Stalls:
//   - noc_credit_i=0 holds noc_data_o/noc_tx_o stable; the state does not advance.
//   - src_tx_i=0 in PASS drives noc_tx_o=0 and leaves remaining unchanged.
//  In CAP states noc_tx_o=0. The block never accepts an input flit and emits a generated flit in the same cycle.
//  task_cnt_o and task_id wrap 0xFFFF->0.
//  noc_data_o is registered in HDR..DAT and combinational in PASS.
// TESTING
//  1. text=8, data=4, bss=16, entry=0x100, 3 words, addr=0x0102
//     -> 0x0102, 9, 0x40, 0, 8, 4, 16, 0x100, w0..w2; pkt_done_o pulse; task_cnt_o=1.
//  2. text=0, data=0 -> size flit=6, packet ends at entry_point; task_cnt_o increments.
//  3. Hold noc_credit_i=0 for 5 cycles during SIZE, then again during PASS
//     -> no flit lost or duplicated; src_credit_o=0 during the PASS stall.
//  4. Random src_tx_i gaps in PASS -> noc_tx_o mirrors the gaps; output sequence identical to test 1.
//  5. Two back-to-back tasks (addr 0x0001, then 0x0100) -> task_id flits 0 and 1; task_cnt_o=2.
//  6. Assert rst_ni mid-binary -> outputs go to reset values; the next task packetizes correctly with task_id=0.

Source files
------------

// File: rtl/ma_task_packetizer.sv
// ---------------------------------------------------------------------------
// ma_task_packetizer
//
// Wraps each task image coming out of the MA parser into a NoC packet aimed
// at the target PE. The parser delivers text_size, data_size, bss_size,
// entry_point and then the binary words. The packet sent to the injector is
// header, size, service, task_id, the four descriptor words and the binary.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous, active-high reset
//   src_tx_i       input flit valid
//   src_credit_o   input ready (flit accepted on src_tx_i & src_credit_o)
//   src_data_i     input flit
//   target_addr_i  destination PE (XY), sampled with text_size
//   noc_tx_o       output flit valid
//   noc_credit_i   NoC ready (flit sent on noc_tx_o & noc_credit_i)
//   noc_data_o     output flit
//   pkt_done_o     one-cycle pulse after the last flit of a packet
//   task_cnt_o     packets completed since reset
// ---------------------------------------------------------------------------
module ma_task_packetizer #(
    parameter int                   FLIT_SIZE = 32,
    parameter logic [FLIT_SIZE-1:0] SVC_ALLOC = FLIT_SIZE'(32'h0000_0040)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 src_tx_i,
    output logic                 src_credit_o,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    input  logic [15:0]          target_addr_i,
    output logic                 noc_tx_o,
    input  logic                 noc_credit_i,
    output logic [FLIT_SIZE-1:0] noc_data_o,
    output logic                 pkt_done_o,
    output logic [15:0]          task_cnt_o
);

    typedef enum logic [3:0] {
        CAP_TEXT,
        CAP_DATA,
        HDR,
        SIZE,
        SVC,
        ID,
        TXT,
        DAT,
        PASS
    } state_t;

    state_t               state;
    logic                 run;
    logic [FLIT_SIZE-1:0] text;
    logic [FLIT_SIZE-1:0] dsz;
    logic [15:0]          dest;
    logic [FLIT_SIZE-1:0] words;
    logic [FLIT_SIZE-1:0] remaining;
    logic [15:0]          task_id;
    logic                 tx_q;
    logic [FLIT_SIZE-1:0] data_q;
    logic                 done_q;
    logic [15:0]          cnt_q;
    logic                 accept;

    // The capture states only become ready once the first clock after reset
    // has set 'run', so the parser never sees credit while reset is applied.
    // In PASS the input ready is simply the NoC ready (zero-latency forward).
    always_comb begin
        src_credit_o = 1'b0;
        case (state)
            CAP_TEXT, CAP_DATA: src_credit_o = run;
            PASS:               src_credit_o = noc_credit_i;
            default:            src_credit_o = 1'b0;
        endcase
    end

    // Generated flits come from registers; the binary is wired straight
    // through so that a stall on either side propagates without buffering.
    assign noc_tx_o   = (state == PASS) ? src_tx_i   : tx_q;
    assign noc_data_o = (state == PASS) ? src_data_i : data_q;
    assign accept     = src_tx_i & src_credit_o;
    assign pkt_done_o = done_q;
    assign task_cnt_o = cnt_q;

    // Main sequencer. Each generated-flit state preloads the flit of the
    // following state when the NoC takes the current one, so data_q always
    // holds the flit being offered.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state     <= CAP_TEXT;
            run       <= 1'b0;
            text      <= '0;
            dsz       <= '0;
            dest      <= '0;
            words     <= '0;
            remaining <= '0;
            task_id   <= '0;
            tx_q      <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            run    <= 1'b1;
            done_q <= 1'b0;
            case (state)
                CAP_TEXT: begin
                    if (accept) begin
                        text  <= src_data_i;
                        dest  <= target_addr_i;
                        state <= CAP_DATA;
                    end
                end
                CAP_DATA: begin
                    if (accept) begin
                        // Word count truncates a partial trailing word.
                        dsz    <= src_data_i;
                        words  <= (text + src_data_i) >> 2;
                        data_q <= FLIT_SIZE'(dest);
                        tx_q   <= 1'b1;
                        state  <= HDR;
                    end
                end
                HDR: begin
                    if (noc_credit_i) begin
                        // Payload = service + id + 4 descriptors + binary.
                        data_q <= words + FLIT_SIZE'(6);
                        state  <= SIZE;
                    end
                end
                SIZE: begin
                    if (noc_credit_i) begin
                        data_q <= SVC_ALLOC;
                        state  <= SVC;
                    end
                end
                SVC: begin
                    if (noc_credit_i) begin
                        data_q <= FLIT_SIZE'(task_id);
                        state  <= ID;
                    end
                end
                ID: begin
                    if (noc_credit_i) begin
                        data_q <= text;
                        state  <= TXT;
                    end
                end
                TXT: begin
                    if (noc_credit_i) begin
                        data_q <= dsz;
                        state  <= DAT;
                    end
                end
                DAT: begin
                    if (noc_credit_i) begin
                        // bss and entry_point still have to pass through.
                        tx_q      <= 1'b0;
                        data_q    <= '0;
                        remaining <= words + FLIT_SIZE'(2);
                        state     <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        remaining <= remaining - FLIT_SIZE'(1);
                        if (remaining == FLIT_SIZE'(1)) begin
                            done_q  <= 1'b1;
                            cnt_q   <= cnt_q + 16'd1;
                            task_id <= task_id + 16'd1;
                            state   <= CAP_TEXT;
                        end
                    end
                end
                default: state <= CAP_TEXT;
            endcase
        end
    end

endmodule
